// File: rtl/vlsu_mem_seq_pkg.sv
// Shared types and constants for the vector memory sequencer.
// Package vlsu_pkg: FSM state encoding and bus constants.
package vlsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [3:0]  BE_FULL    = 4'hF;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/vlsu_mem_seq_if.sv
// Command, store-data, load-data and downstream arbiter bundle.
// slave: the sequencer; master: the command issuer / memory side.
interface vlsu_mem_seq_if #(
  parameter int unsigned LEN_W = 8
) ();

  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             cmd_store_i;
  logic [31:0]      cmd_base_i;
  logic [31:0]      cmd_stride_i;
  logic [LEN_W-1:0] cmd_len_i;

  logic             wdata_valid_i;
  logic             wdata_ready_o;
  logic [31:0]      wdata_i;

  logic             rdata_valid_o;
  logic [31:0]      rdata_o;
  logic             done_o;
  logic             err_o;

  logic             vdata_req_o;
  logic             vdata_we_o;
  logic [3:0]       vdata_be_o;
  logic [31:0]      vdata_addr_o;
  logic [31:0]      vdata_wdata_o;
  logic             vdata_gnt_i;
  logic             vdata_rvalid_i;
  logic             vdata_err_i;
  logic [31:0]      vdata_rdata_i;

  logic             vect_pending_load_o;
  logic             vect_pending_store_o;

  modport slave (
    input  cmd_valid_i, cmd_store_i, cmd_base_i,
    input  cmd_stride_i, cmd_len_i,
    output cmd_ready_o,
    input  wdata_valid_i, wdata_i,
    output wdata_ready_o,
    output rdata_valid_o, rdata_o, done_o, err_o,
    output vdata_req_o, vdata_we_o, vdata_be_o,
    output vdata_addr_o, vdata_wdata_o,
    input  vdata_gnt_i, vdata_rvalid_i,
    input  vdata_err_i, vdata_rdata_i,
    output vect_pending_load_o, vect_pending_store_o
  );

  modport master (
    output cmd_valid_i, cmd_store_i, cmd_base_i,
    output cmd_stride_i, cmd_len_i,
    input  cmd_ready_o,
    output wdata_valid_i, wdata_i,
    input  wdata_ready_o,
    input  rdata_valid_o, rdata_o, done_o, err_o,
    input  vdata_req_o, vdata_we_o, vdata_be_o,
    input  vdata_addr_o, vdata_wdata_o,
    output vdata_gnt_i, vdata_rvalid_i,
    output vdata_err_i, vdata_rdata_i,
    input  vect_pending_load_o, vect_pending_store_o
  );

endinterface

// File: rtl/vlsu_mem_seq_addr_gen.sv
// Word address generator: base load, per-word advance, word alignment.
// VLSU_MEM_SEQ_STRIDE_EN selects programmable stride vs fixed +4.
module vlsu_addr_gen
  import vlsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [29:0] base_i,
`ifdef VLSU_MEM_SEQ_STRIDE_EN
  input  logic [29:0] stride_i,
`endif
  input  logic        step_i,
  output logic [31:0] addr_o
);

  logic [29:0] waddr_q;
  logic [29:0] inc;

`ifdef VLSU_MEM_SEQ_STRIDE_EN
  logic [29:0] stride_q;
  assign inc = stride_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stride_q <= '0;
    end else if (load_i) begin
      stride_q <= stride_i;
    end
  end
`else
  assign inc = 30'(WORD_BYTES / 4);
`endif

  // Base is aligned, so adding word-granular stride keeps bits [1:0] zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      waddr_q <= '0;
    end else if (load_i) begin
      waddr_q <= base_i;
    end else if (step_i) begin
      waddr_q <= waddr_q + inc;
    end
  end

  assign addr_o = {waddr_q, 2'b00};

endmodule

// File: rtl/vlsu_mem_seq.sv
// Vector load/store sequencer: one word access at a time to the arbiter.
// VLSU_MEM_SEQ_STRIDE_EN enables programmable byte stride.
module vlsu_mem_seq
  import vlsu_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input logic           clk_i,
  input logic           rst_ni,
  vlsu_mem_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic             store_q;
  logic [LEN_W-1:0] rem_q;
  logic [31:0]      wbuf_q;
  logic             err_q;
  logic             rvld_q;
  logic [31:0]      rdata_q;
  logic [31:0]      addr;
  logic             accept;
  logic             resp;
  logic             last;
  logic             busy;
  logic             unused_bits;

  assign accept = (state_q == S_IDLE) & bus.cmd_valid_i;
  assign resp   = (state_q == S_WAIT) & bus.vdata_rvalid_i;
  assign last   = (rem_q == LEN_W'(1));
  assign busy   = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          if (bus.cmd_len_i == '0) state_d = S_DONE;
          else if (bus.cmd_store_i) state_d = S_FETCH;
          else state_d = S_REQ;
        end
      end
      S_FETCH: if (bus.wdata_valid_i) state_d = S_REQ;
      S_REQ:   if (bus.vdata_gnt_i) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.vdata_rvalid_i) begin
          if (last | bus.vdata_err_i) state_d = S_DONE;
          else if (store_q) state_d = S_FETCH;
          else state_d = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      rem_q   <= '0;
      wbuf_q  <= '0;
      err_q   <= 1'b0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rvld_q  <= resp & ~store_q;
      if (resp & ~store_q) rdata_q <= bus.vdata_rdata_i;
      if (accept) begin
        store_q <= bus.cmd_store_i;
        rem_q   <= bus.cmd_len_i;
        err_q   <= 1'b0;
      end else if (resp) begin
        rem_q <= rem_q - LEN_W'(1);
        if (bus.vdata_err_i) err_q <= 1'b1;
      end
      if ((state_q == S_FETCH) & bus.wdata_valid_i) begin
        wbuf_q <= bus.wdata_i;
      end
    end
  end

  vlsu_addr_gen u_addr_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (accept),
    .base_i   (bus.cmd_base_i[31:2]),
`ifdef VLSU_MEM_SEQ_STRIDE_EN
    .stride_i (bus.cmd_stride_i[31:2]),
`endif
    .step_i   (resp),
    .addr_o   (addr)
  );

`ifdef VLSU_MEM_SEQ_STRIDE_EN
  assign unused_bits = ^{bus.cmd_base_i[1:0], bus.cmd_stride_i[1:0]};
`else
  assign unused_bits = ^{bus.cmd_base_i[1:0], bus.cmd_stride_i};
`endif

  assign bus.cmd_ready_o   = (state_q == S_IDLE);
  assign bus.wdata_ready_o = (state_q == S_FETCH);
  assign bus.rdata_valid_o = rvld_q;
  assign bus.rdata_o       = rdata_q;
  assign bus.done_o        = (state_q == S_DONE);
  assign bus.err_o         = err_q;

  assign bus.vdata_req_o   = (state_q == S_REQ);
  assign bus.vdata_we_o    = (state_q == S_REQ) & store_q;
  assign bus.vdata_be_o    = (state_q == S_REQ) ? BE_FULL : 4'h0;
  assign bus.vdata_addr_o  = addr;
  assign bus.vdata_wdata_o = wbuf_q;

  assign bus.vect_pending_load_o  = busy & ~store_q;
  assign bus.vect_pending_store_o = busy & store_q;

endmodule

// File: tb/tb_vlsu_mem_seq.sv
// Self-checking bench for vlsu_mem_seq with a memory responder model.
// Address expectations follow VLSU_MEM_SEQ_STRIDE_EN when defined.
`timescale 1ns/1ps
module tb_vlsu_mem_seq;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  vlsu_mem_seq_if #(.LEN_W(8)) bus ();

  vlsu_mem_seq #(.LEN_W(8)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  bit          resp_en = 1'b1;
  int          gnt_delay = 0;
  int          err_at = -1;
  int          word_idx = 0;
  int          wait_cnt = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr;
  logic        pend_we;
  logic        man_gnt = 1'b0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = '0;

  logic [31:0] got_addr[$];
  logic [31:0] got_wdata[$];
  logic        got_we[$];
  logic [31:0] got_rdata[$];
  logic [31:0] exp_rdata[$];
  logic [31:0] exp_wdata[$];

  int   n_done, n_rdata, n_req, n_pend;
  int   unstable, order_bad, done_idx;
  bit   timeout;
  logic err_first;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A00;
  endfunction

  function automatic logic [31:0] exp_step(input logic [31:0] s);
`ifdef VLSU_MEM_SEQ_STRIDE_EN
    return s;
`else
    return 32'd4;
`endif
  endfunction

  always @(negedge clk_i) begin
    bus.vdata_gnt_i    = 1'b0;
    bus.vdata_rvalid_i = 1'b0;
    bus.vdata_err_i    = 1'b0;
    if (!resp_en) begin
      pend = 1'b0;
      wait_cnt = 0;
      bus.vdata_gnt_i    = man_gnt;
      bus.vdata_rvalid_i = man_rvalid;
      bus.vdata_rdata_i  = man_rdata;
    end else if (!rst_ni) begin
      pend = 1'b0;
      wait_cnt = 0;
    end else if (pend) begin
      bus.vdata_rvalid_i = 1'b1;
      bus.vdata_rdata_i  = mem_word(pend_addr);
      bus.vdata_err_i    = (word_idx == err_at);
      if (!pend_we) exp_rdata.push_back(mem_word(pend_addr));
      word_idx++;
      pend = 1'b0;
    end else if (bus.vdata_req_o) begin
      if (wait_cnt >= gnt_delay) begin
        bus.vdata_gnt_i = 1'b1;
        got_addr.push_back(bus.vdata_addr_o);
        got_we.push_back(bus.vdata_we_o);
        got_wdata.push_back(bus.vdata_wdata_o);
        pend = 1'b1;
        pend_addr = bus.vdata_addr_o;
        pend_we = bus.vdata_we_o;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic run_cmd(input bit st, input logic [31:0] base,
                         input logic [31:0] stride, input int len,
                         input int wdelay, input int gd, input int ea);
    bit          prev_req = 1'b0;
    bit          prev_gnt = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wd = '0;
    logic [3:0]  prev_be = '0;
    logic        prev_we = 1'b0;
    logic [31:0] last_w = '0;
    int          wsent = 0;
    int          wwait = 0;
    got_addr.delete(); got_wdata.delete(); got_we.delete();
    got_rdata.delete(); exp_rdata.delete(); exp_wdata.delete();
    n_done = 0; n_rdata = 0; n_req = 0; n_pend = 0;
    unstable = 0; order_bad = 0; done_idx = -1; timeout = 1'b1;
    gnt_delay = gd; err_at = ea; word_idx = 0;
    bus.cmd_store_i  = st;
    bus.cmd_base_i   = base;
    bus.cmd_stride_i = stride;
    bus.cmd_len_i    = 8'(len);
    bus.cmd_valid_i  = 1'b1;
    @(negedge clk_i); #1;
    bus.cmd_valid_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 0) err_first = bus.err_o;
      if (bus.done_o) begin
        if (n_done == 0) done_idx = i;
        n_done++;
      end
      if (bus.rdata_valid_o) begin
        n_rdata++;
        got_rdata.push_back(bus.rdata_o);
      end
      if (bus.vect_pending_load_o | bus.vect_pending_store_o) n_pend++;
      if (bus.vdata_req_o) begin
        n_req++;
        if (prev_req && !prev_gnt &&
            (bus.vdata_addr_o !== prev_addr ||
             bus.vdata_wdata_o !== prev_wd ||
             bus.vdata_be_o !== prev_be ||
             bus.vdata_we_o !== prev_we)) unstable++;
        if (st && (wsent == 0 || bus.vdata_wdata_o !== last_w)) order_bad++;
      end
      prev_req  = bus.vdata_req_o;
      prev_gnt  = bus.vdata_gnt_i;
      prev_addr = bus.vdata_addr_o;
      prev_wd   = bus.vdata_wdata_o;
      prev_be   = bus.vdata_be_o;
      prev_we   = bus.vdata_we_o;
      if (bus.wdata_ready_o) begin
        if (wwait >= wdelay) begin
          last_w = 32'hC0DE_0000 | 32'(wsent) | (base << 4);
          bus.wdata_valid_i = 1'b1;
          bus.wdata_i = last_w;
          exp_wdata.push_back(last_w);
          wsent++;
          wwait = 0;
        end else begin
          bus.wdata_valid_i = 1'b0;
          wwait++;
        end
      end else begin
        bus.wdata_valid_i = 1'b0;
      end
      if (n_done > 0 && !bus.done_o) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk_i); #1;
    end
    bus.wdata_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus.cmd_ready_o);
    end
    checks++;
    if (bus.vdata_req_o !== 1'b0 || bus.vdata_we_o !== 1'b0 ||
        bus.vdata_be_o !== 4'h0 || bus.vdata_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_vdata: got req=%b we=%b be=%h addr=%h want all 0",
               bus.vdata_req_o, bus.vdata_we_o, bus.vdata_be_o,
               bus.vdata_addr_o);
    end
    checks++;
    if (bus.done_o !== 1'b0 || bus.err_o !== 1'b0 ||
        bus.rdata_valid_o !== 1'b0 || bus.wdata_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got done=%b err=%b rv=%b wr=%b want 0",
               bus.done_o, bus.err_o, bus.rdata_valid_o, bus.wdata_ready_o);
    end
    checks++;
    if (bus.vect_pending_load_o !== 1'b0 ||
        bus.vect_pending_store_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending: got %b%b want 00",
               bus.vect_pending_load_o, bus.vect_pending_store_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i); #1;
  endtask

  task automatic test_load();
    logic [31:0] ea;
    run_cmd(1'b0, 32'h100, 32'd4, 3, 0, 0, -1);
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL load_timeout: got no done want done");
    end
    checks++;
    if (n_req !== 3) begin
      errors++;
      $display("FAIL load_req_cycles: got %0d want 3", n_req);
    end
    checks++;
    if (got_addr.size() != 3) begin
      errors++;
      $display("FAIL load_nreq: got %0d want 3", got_addr.size());
    end
    for (int k = 0; k < 3 && k < got_addr.size(); k++) begin
      ea = 32'h100 + 32'(k) * exp_step(32'd4);
      checks++;
      if (got_addr[k] !== ea || got_we[k] !== 1'b0) begin
        errors++;
        $display("FAIL load_addr%0d: got %h we=%b want %h we=0",
                 k, got_addr[k], got_we[k], ea);
      end
    end
    checks++;
    if (n_rdata !== 3) begin
      errors++;
      $display("FAIL load_rdata_n: got %0d want 3", n_rdata);
    end
    for (int k = 0; k < got_rdata.size() && k < exp_rdata.size(); k++) begin
      checks++;
      if (got_rdata[k] !== exp_rdata[k]) begin
        errors++;
        $display("FAIL load_rdata%0d: got %h want %h",
                 k, got_rdata[k], exp_rdata[k]);
      end
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL load_done: got %0d want 1", n_done);
    end
  endtask

  task automatic test_store();
    logic [31:0] ea;
    run_cmd(1'b1, 32'h200, 32'hFFFF_FFF8, 2, 3, 0, -1);
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL store_timeout: got no done want done");
    end
    checks++;
    if (got_addr.size() != 2) begin
      errors++;
      $display("FAIL store_nreq: got %0d want 2", got_addr.size());
    end
    for (int k = 0; k < 2 && k < got_addr.size(); k++) begin
      ea = 32'h200 + 32'(k) * exp_step(32'hFFFF_FFF8);
      checks++;
      if (got_addr[k] !== ea || got_we[k] !== 1'b1) begin
        errors++;
        $display("FAIL store_addr%0d: got %h we=%b want %h we=1",
                 k, got_addr[k], got_we[k], ea);
      end
      checks++;
      if (k < exp_wdata.size() && got_wdata[k] !== exp_wdata[k]) begin
        errors++;
        $display("FAIL store_wdata%0d: got %h want %h",
                 k, got_wdata[k], exp_wdata[k]);
      end
    end
    checks++;
    if (order_bad !== 0) begin
      errors++;
      $display("FAIL store_req_order: got %0d early reqs want 0", order_bad);
    end
    checks++;
    if (n_rdata !== 0 || n_done !== 1) begin
      errors++;
      $display("FAIL store_pulses: got rdata=%0d done=%0d want 0/1",
               n_rdata, n_done);
    end
  endtask

  task automatic test_len0();
    run_cmd(1'b0, 32'h300, 32'd4, 0, 0, 0, -1);
    checks++;
    if (n_req !== 0) begin
      errors++;
      $display("FAIL len0_req: got %0d want 0", n_req);
    end
    checks++;
    if (done_idx !== 0 || n_done !== 1) begin
      errors++;
      $display("FAIL len0_done: got idx=%0d n=%0d want 0/1", done_idx, n_done);
    end
    checks++;
    if (n_pend !== 1) begin
      errors++;
      $display("FAIL len0_pending: got %0d want 1", n_pend);
    end
  endtask

  task automatic test_error();
    run_cmd(1'b0, 32'h500, 32'd4, 4, 0, 0, 1);
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL err_timeout: got no done want done");
    end
    checks++;
    if (got_addr.size() != 2 || n_req !== 2) begin
      errors++;
      $display("FAIL err_nreq: got %0d want 2", got_addr.size());
    end
    checks++;
    if (n_rdata !== 2) begin
      errors++;
      $display("FAIL err_rdata_n: got %0d want 2", n_rdata);
    end
    checks++;
    if (bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", bus.err_o);
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL err_done: got %0d want 1", n_done);
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(1'b0, 32'h600, 32'd4, 1, 0, 0, -1);
    checks++;
    if (err_first !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b want 0", err_first);
    end
    checks++;
    if (n_rdata !== 1 || got_rdata.size() != 1 || exp_rdata.size() != 1 ||
        got_rdata[0] !== exp_rdata[0]) begin
      errors++;
      $display("FAIL b2b_rdata: got n=%0d want 1 word %h",
               n_rdata, mem_word(32'h600));
    end
    checks++;
    if (bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_err: got %b want 0", bus.err_o);
    end
  endtask

  task automatic test_gnt_delay();
    run_cmd(1'b1, 32'h700, 32'd4, 2, 0, 5, -1);
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL gdly_timeout: got no done want done");
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL gdly_stable: got %0d changes want 0", unstable);
    end
    checks++;
    if (n_req !== 12) begin
      errors++;
      $display("FAIL gdly_req_held: got %0d want 12", n_req);
    end
    checks++;
    if (got_wdata.size() != 2 || exp_wdata.size() != 2 ||
        got_wdata[0] !== exp_wdata[0] || got_wdata[1] !== exp_wdata[1]) begin
      errors++;
      $display("FAIL gdly_wdata: got %0d words want 2 matching",
               got_wdata.size());
    end
  endtask

  task automatic test_stride_cfg();
    logic [31:0] ea;
    run_cmd(1'b0, 32'h800, 32'h40, 3, 0, 0, -1);
    checks++;
    if (got_addr.size() != 3) begin
      errors++;
      $display("FAIL stride_nreq: got %0d want 3", got_addr.size());
    end
    for (int k = 0; k < 3 && k < got_addr.size(); k++) begin
      ea = 32'h800 + 32'(k) * exp_step(32'h40);
      checks++;
      if (got_addr[k] !== ea) begin
        errors++;
        $display("FAIL stride_addr%0d: got %h want %h", k, got_addr[k], ea);
      end
    end
  endtask

  task automatic test_done_no_accept();
    bus.cmd_store_i = 1'b0;
    bus.cmd_base_i  = 32'h900;
    bus.cmd_len_i   = 8'd0;
    bus.cmd_valid_i = 1'b1;
    @(negedge clk_i); #1;
    checks++;
    if (bus.done_o !== 1'b1 || bus.cmd_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL dna_done: got done=%b rdy=%b want 1/0",
               bus.done_o, bus.cmd_ready_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if (bus.done_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 ||
        bus.vect_pending_load_o !== 1'b0) begin
      errors++;
      $display("FAIL dna_not_taken: got done=%b rdy=%b pend=%b want 0/1/0",
               bus.done_o, bus.cmd_ready_o, bus.vect_pending_load_o);
    end
    bus.cmd_valid_i = 1'b0;
    @(negedge clk_i); #1;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    resp_en = 1'b0;
    man_gnt = 1'b0;
    man_rvalid = 1'b0;
    bus.cmd_store_i = 1'b0;
    bus.cmd_base_i  = 32'hA00;
    bus.cmd_len_i   = 8'd2;
    bus.cmd_valid_i = 1'b1;
    @(negedge clk_i); #1;
    bus.cmd_valid_i = 1'b0;
    checks++;
    if (bus.vdata_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rmid_req: got %b want 1", bus.vdata_req_o);
    end
    man_gnt = 1'b1;
    @(negedge clk_i); #1;
    man_gnt = 1'b0;
    @(negedge clk_i); #1;
    checks++;
    if (bus.vdata_req_o !== 1'b0 || bus.vect_pending_load_o !== 1'b1) begin
      errors++;
      $display("FAIL rmid_wait: got req=%b pend=%b want 0/1",
               bus.vdata_req_o, bus.vect_pending_load_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready_o !== 1'b1 || bus.done_o !== 1'b0 ||
        bus.vect_pending_load_o !== 1'b0 || bus.vdata_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL rmid_async: got rdy=%b done=%b pend=%b addr=%h want 1/0/0/0",
               bus.cmd_ready_o, bus.done_o, bus.vect_pending_load_o,
               bus.vdata_addr_o);
    end
    @(negedge clk_i); #1;
    rst_ni = 1'b1;
    man_rvalid = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    @(negedge clk_i); #1;
    man_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rdata_valid_o || bus.done_o || !bus.cmd_ready_o) bad++;
      @(negedge clk_i); #1;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rmid_stray: got %0d bad cycles want 0", bad);
    end
    resp_en = 1'b1;
    @(negedge clk_i); #1;
  endtask

  initial begin
    bus.cmd_valid_i   = 1'b0;
    bus.cmd_store_i   = 1'b0;
    bus.cmd_base_i    = '0;
    bus.cmd_stride_i  = '0;
    bus.cmd_len_i     = '0;
    bus.wdata_valid_i = 1'b0;
    bus.wdata_i       = '0;
    test_reset();
    test_load();
    test_store();
    test_len0();
    test_error();
    test_back_to_back();
    test_gnt_delay();
    test_stride_cfg();
    test_done_no_accept();
    test_reset_mid();
    test_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
